// File: rtl/ieee_to_int_if.sv
// Handshake bundle for the FP16 -> integer converter.
// Input and output channels each use valid/ready.
interface ieee_to_int_if #(
  parameter int OUT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      float_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] int_out;
  logic             out_ovf;
  logic             out_nan;

  modport master (
    output in_valid, float_in, out_ready,
    input  in_ready, out_valid, int_out, out_ovf, out_nan
  );

  modport slave (
    input  in_valid, float_in, out_ready,
    output in_ready, out_valid, int_out, out_ovf, out_nan
  );
endinterface

// File: rtl/ieee_to_int.sv
// Iterative FP16 -> saturated integer, round-to-nearest-even.
// One alignment bit per cycle; result held until consumed.
module ieee_to_int #(
  parameter int OUT_W      = 16,
  parameter bit SIGNED_OUT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  ieee_to_int_if.slave bus
);
  localparam int W = ((OUT_W > 16) ? OUT_W : 16) + 1;
  localparam logic [W-1:0] UMAX = W'({OUT_W{1'b1}});
  localparam logic [W-1:0] SMAX = W'({(OUT_W-1){1'b1}});
  localparam logic [W-1:0] SMIN =
    {{(W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, HOLD} state_t;

  state_t       state;
  logic [W-1:0] mag;
  logic [4:0]   cnt;
  logic         left;
  logic         guard;
  logic         sticky;
  logic         sgn;
  logic         nan_r;
  logic         phase;

  logic [4:0]       d_e;
  logic [9:0]       d_m;
  logic [10:0]      d_sig;
  logic [4:0]       d_ex;
  logic             d_left;
  logic [4:0]       d_k;
  logic             inc;
  logic [OUT_W-1:0] res;
  logic             ovf;

  always_comb begin
    d_e    = bus.float_in[14:10];
    d_m    = bus.float_in[9:0];
    d_sig  = {(d_e != 5'd0), d_m};
    d_ex   = (d_e == 5'd0) ? 5'd1 : d_e;
    d_left = d_ex > 5'd25;
    d_k    = d_left ? (d_ex - 5'd25) : (5'd25 - d_ex);
  end

  assign inc = guard & (sticky | mag[0]);

  // mag is wide enough to hold any finite FP16 magnitude
  always_comb begin
    res = '0;
    ovf = 1'b0;
    if (!SIGNED_OUT) begin
      if (sgn) begin
        ovf = (mag != '0);
      end else if (mag > UMAX) begin
        res = '1;
        ovf = 1'b1;
      end else begin
        res = mag[OUT_W-1:0];
      end
    end else begin
      if (!sgn && mag > SMAX) begin
        res = {1'b0, {(OUT_W-1){1'b1}}};
        ovf = 1'b1;
      end else if (sgn && mag > SMIN) begin
        res = {1'b1, {(OUT_W-1){1'b0}}};
        ovf = 1'b1;
      end else if (sgn) begin
        res = -mag[OUT_W-1:0];
      end else begin
        res = mag[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.int_out   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_nan   <= 1'b0;
      mag           <= '0;
      cnt           <= '0;
      left          <= 1'b0;
      guard         <= 1'b0;
      sticky        <= 1'b0;
      sgn           <= 1'b0;
      nan_r         <= 1'b0;
      phase         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            sgn          <= bus.float_in[15];
            nan_r        <= 1'b0;
            guard        <= 1'b0;
            sticky       <= 1'b0;
            phase        <= 1'b0;
            left         <= d_left;
            cnt          <= d_k;
            if (d_e == 5'd31) begin
              // Inf as all-ones lets saturation logic pick max/min
              cnt   <= '0;
              mag   <= (d_m != 10'd0) ? '0 : '1;
              nan_r <= (d_m != 10'd0);
              if (d_m != 10'd0) sgn <= 1'b0;
              state <= ROUND;
            end else if (d_ex < 5'd13) begin
              cnt   <= '0;
              mag   <= '0;
              state <= ROUND;
            end else begin
              mag   <= W'(d_sig);
              state <= (d_k == 5'd0) ? ROUND : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (left) begin
            mag <= mag << 1;
          end else begin
            mag    <= mag >> 1;
            guard  <= mag[0];
            sticky <= sticky | guard;
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= ROUND;
        end
        ROUND: begin
          if (!phase) begin
            mag   <= mag + W'(inc);
            phase <= 1'b1;
          end else begin
            bus.int_out   <= res;
            bus.out_ovf   <= ovf;
            bus.out_nan   <= nan_r;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
